// File: rtl/axis_arb_rr.sv
// axis_arb_rr: round-robin arbiter sharing one AXI-stream channel between
// NUM_PORTS requesters. One port is granted for a burst of up to BURST_LEN
// beats. Beats pass through a registered output stage and are tagged with
// the index of their source port on m_axis_tdest.
//
// Ports:
//   clk            core clock, rising edge
//   rst            synchronous, active-high reset
//   s_axis_tvalid  per-port valid (bit i = port i)
//   s_axis_tready  per-port ready, at most one bit high
//   s_axis_tdata   packed data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   m_axis_tvalid  registered output valid
//   m_axis_tready  downstream ready
//   m_axis_tdata   registered output data
//   m_axis_tdest   source port index of the current output beat
module axis_arb_rr #(
  parameter int unsigned NUM_PORTS  = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEST_WIDTH = 2,
  parameter int unsigned BURST_LEN  = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_PORTS-1:0]             s_axis_tvalid,
  output logic [NUM_PORTS-1:0]             s_axis_tready,
  input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [DATA_WIDTH-1:0]            m_axis_tdata,
  output logic [DEST_WIDTH-1:0]            m_axis_tdest
);

  localparam int unsigned CW = $clog2(BURST_LEN + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [DEST_WIDTH-1:0] grant_q, grant_d;
  logic [DEST_WIDTH-1:0] last_q,  last_d;
  logic [CW-1:0]         cnt_q,   cnt_d;
  logic                  mvalid_q, mvalid_d;
  logic [DATA_WIDTH-1:0] mdata_q,  mdata_d;
  logic [DEST_WIDTH-1:0] mdest_q,  mdest_d;

  logic [DEST_WIDTH-1:0] start;
  logic [NUM_PORTS-1:0]  rot;
  logic [DEST_WIDTH-1:0] pick;
  logic                  pick_found;
  logic                  sel_valid;
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  out_ready;
  logic                  s_frame;
  logic                  m_frame;
  logic [CW-1:0]         cnt_inc;

  // Round-robin search: rotate the request vector so that bit 0 is the port
  // after last_grant, take the first set bit, then map back to a port index.
  always_comb begin
    start      = (last_q == DEST_WIDTH'(NUM_PORTS - 1)) ? '0 : last_q + DEST_WIDTH'(1);
    rot        = NUM_PORTS'({s_axis_tvalid, s_axis_tvalid} >> start);
    pick       = '0;
    pick_found = 1'b0;
    for (int unsigned j = 0; j < NUM_PORTS; j++) begin
      if (!pick_found && rot[j]) begin
        pick_found = 1'b1;
        pick       = DEST_WIDTH'((32'(start) + j) % NUM_PORTS);
      end
    end
  end

  // Granted-port mux and ready fan-out; ready is combinational from m_axis_tready.
  assign out_ready = ~mvalid_q | m_axis_tready;

  always_comb begin
    sel_valid     = 1'b0;
    sel_data      = '0;
    s_axis_tready = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      if (grant_q == DEST_WIDTH'(i)) begin
        sel_valid        = s_axis_tvalid[i];
        sel_data         = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
        s_axis_tready[i] = (state_q == GRANT) && out_ready;
      end
    end
  end

  assign s_frame = (state_q == GRANT) && sel_valid && out_ready;
  assign m_frame = mvalid_q && m_axis_tready;
  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE) begin
      if (pick_found) begin
        grant_d = pick;
        cnt_d   = '0;
        state_d = GRANT;
      end
    end else begin
      if (!sel_valid) begin
        state_d = IDLE;
        last_d  = grant_q;
      end else if (s_frame) begin
        if (cnt_inc == CW'(BURST_LEN)) begin
          state_d = IDLE;
          last_d  = grant_q;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
    end
  end

  // A new load takes precedence over draining, so valid stays high when
  // both handshakes coincide.
  always_comb begin
    mvalid_d = mvalid_q;
    mdata_d  = mdata_q;
    mdest_d  = mdest_q;
    if (s_frame) begin
      mvalid_d = 1'b1;
      mdata_d  = sel_data;
      mdest_d  = grant_q;
    end else if (m_frame) begin
      mvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      last_q   <= DEST_WIDTH'(NUM_PORTS - 1);
      cnt_q    <= '0;
      mvalid_q <= 1'b0;
      mdata_q  <= '0;
      mdest_q  <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      mvalid_q <= mvalid_d;
      mdata_q  <= mdata_d;
      mdest_q  <= mdest_d;
    end
  end

  assign m_axis_tvalid = mvalid_q;
  assign m_axis_tdata  = mdata_q;
  assign m_axis_tdest  = mdest_q;

endmodule

// File: tb/tb_axis_arb_rr.sv
// Testbench for axis_arb_rr: a BURST_LEN=16 instance for most scenarios and
// a BURST_LEN=1 instance for the alternating single-beat case.
module tb_axis_arb_rr;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   s_valid, s_ready;
  logic [127:0] s_data;
  logic         m_valid, m_ready;
  logic [31:0]  m_data;
  logic [1:0]   m_dest;

  logic [3:0]   s_valid1, s_ready1;
  logic [127:0] s_data1;
  logic         m_valid1, m_ready1;
  logic [31:0]  m_data1;
  logic [1:0]   m_dest1;

  always #5 clk = ~clk;

  axis_arb_rr #(.NUM_PORTS(4), .DATA_WIDTH(32), .DEST_WIDTH(2), .BURST_LEN(16)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
    .m_axis_tdata(m_data), .m_axis_tdest(m_dest)
  );

  axis_arb_rr #(.NUM_PORTS(4), .DATA_WIDTH(32), .DEST_WIDTH(2), .BURST_LEN(1)) dut1 (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_valid1), .s_axis_tready(s_ready1), .s_axis_tdata(s_data1),
    .m_axis_tvalid(m_valid1), .m_axis_tready(m_ready1),
    .m_axis_tdata(m_data1), .m_axis_tdest(m_dest1)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: s-side handshakes push {port, data}; m-side handshakes pop.
  logic [33:0] exp_q[$];
  logic [33:0] log_q[$];
  bit          log_en = 1'b0;
  logic [3:0]  hs_last = '0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_data;
  logic [1:0]  prev_dest;

  initial forever begin
    logic [33:0] e;
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      hs_last    = '0;
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        check("hold_valid", m_valid, 1);
        check("hold_data", m_data, prev_data);
        check("hold_dest", m_dest, prev_dest);
      end
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL sb_beat: got 0x%0h, want no beat", {m_dest, m_data});
        end else begin
          e = exp_q.pop_front();
          check("sb_beat", {m_dest, m_data}, e);
        end
        if (log_en) log_q.push_back({m_dest, m_data});
      end
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_dest  = m_dest;
      hs_last    = s_valid & s_ready;
      for (int i = 0; i < 4; i++)
        if (hs_last[i]) exp_q.push_back({2'(i), s_data[i*32 +: 32]});
    end
  end

  // Per-port source model: left beats remaining, val next data, gap forces valid low.
  int          left[4];
  logic [31:0] val[4];
  bit          gap[4];
  int          acc[4];
  bit          auto_en = 1'b0;

  task automatic drive();
    if (auto_en)
      for (int i = 0; i < 4; i++) begin
        s_valid[i]         = (left[i] > 0) && !gap[i];
        s_data[i*32 +: 32] = val[i];
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (hs_last[i]) begin
        left[i]--;
        val[i]++;
        acc[i]++;
      end
    drive();
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    auto_en  = 1'b0;
    s_valid  = '0;
    s_data   = '0;
    m_ready  = 1'b1;
    s_valid1 = '0;
    s_data1  = '0;
    m_ready1 = 1'b1;
    log_en   = 1'b0;
    log_q.delete();
    for (int i = 0; i < 4; i++) begin
      left[i] = 0; val[i] = '0; gap[i] = 1'b0; acc[i] = 0;
    end
    repeat (2) tick();
    rst = 1'b0;
  endtask

  function automatic bit quiet();
    bit q = (exp_q.size() == 0) && !m_valid;
    for (int i = 0; i < 4; i++) if (left[i] > 0) q = 1'b0;
    return q;
  endfunction

  task automatic wait_drain(input string name);
    m_ready = 1'b1;
    for (int k = 0; k < 300; k++) begin
      if (quiet()) break;
      tick();
    end
    check({"drain_q_", name}, exp_q.size(), 0);
    check({"drain_mv_", name}, m_valid, 0);
  endtask

  typedef struct {
    logic [3:0] sv;
    logic [7:0] d2;
    logic       mr;
    logic [3:0] rdy;
    logic       mv;
    logic [7:0] md;
    logic [1:0] mdst;
  } vec_t;

  vec_t tv[8];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [3:0]  exp_rdy;
    logic        exp_mv;
    logic [1:0]  exp_dst;
    logic [31:0] exp_dat;
    logic [3:0]  pat;
    logic [33:0] t6_exp[8];
    bit          gapped;
    int          k, j;

    // ---- reset state ----
    do_reset();
    @(negedge clk);
    check("rst_tready", s_ready, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_mdata", m_data, 0);
    check("rst_mdest", m_dest, 0);
    check("rst_tready1", s_ready1, 0);
    check("rst_mvalid1", m_valid1, 0);
    tick();

    // ---- test 1: single port 2, 4 beats, table-driven ----
    tv[0] = '{4'b0100, 8'hA0, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    tv[1] = '{4'b0100, 8'hA0, 1'b1, 4'b0100, 1'b0, 8'h00, 2'd0};
    tv[2] = '{4'b0100, 8'hA1, 1'b1, 4'b0100, 1'b1, 8'hA0, 2'd2};
    tv[3] = '{4'b0100, 8'hA2, 1'b1, 4'b0100, 1'b1, 8'hA1, 2'd2};
    tv[4] = '{4'b0100, 8'hA3, 1'b1, 4'b0100, 1'b1, 8'hA2, 2'd2};
    tv[5] = '{4'b0000, 8'h00, 1'b1, 4'b0100, 1'b1, 8'hA3, 2'd2};
    tv[6] = '{4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    tv[7] = '{4'b0000, 8'h00, 1'b1, 4'b0000, 1'b0, 8'h00, 2'd0};
    for (int r = 0; r < 8; r++) begin
      s_valid          = tv[r].sv;
      s_data           = '0;
      s_data[64 +: 32] = 32'(tv[r].d2);
      m_ready          = tv[r].mr;
      @(negedge clk);
      check($sformatf("t1_tready[%0d]", r), s_ready, tv[r].rdy);
      check($sformatf("t1_mvalid[%0d]", r), m_valid, tv[r].mv);
      if (tv[r].mv) begin
        check($sformatf("t1_mdata[%0d]", r), m_data, 32'(tv[r].md));
        check($sformatf("t1_mdest[%0d]", r), m_dest, tv[r].mdst);
      end
      tick();
    end
    wait_drain("t1");

    // ---- test 2: all ports busy, 16-beat bursts, 1 idle cycle each ----
    do_reset();
    for (int i = 0; i < 4; i++) begin
      left[i] = 200;
      val[i]  = 32'(i) << 8;
    end
    auto_en = 1'b1;
    drive();
    for (int c = 0; c < 2 + 8 * 17; c++) begin
      @(negedge clk);
      if (c == 0) exp_rdy = '0;
      else begin
        k = c - 1;
        exp_rdy = (k % 17 < 16) ? (4'b0001 << ((k / 17) % 4)) : 4'b0000;
      end
      exp_mv  = 1'b0;
      exp_dst = '0;
      if (c >= 2) begin
        j = c - 2;
        exp_mv  = (j % 17 < 16);
        exp_dst = 2'((j / 17) % 4);
      end
      check($sformatf("t2_tready[%0d]", c), s_ready, exp_rdy);
      check($sformatf("t2_mvalid[%0d]", c), m_valid, exp_mv);
      if (exp_mv) check($sformatf("t2_mdest[%0d]", c), m_dest, exp_dst);
      tick();
    end
    for (int i = 0; i < 4; i++) left[i] = 0;
    drive();
    wait_drain("t2");

    // ---- test 3: backpressure 1,0,0,1 on port 1 stream 1..8 ----
    do_reset();
    left[1] = 8;
    val[1]  = 32'd1;
    auto_en = 1'b1;
    log_en  = 1'b1;
    pat     = 4'b1001;
    drive();
    for (int c = 0; c < 120; c++) begin
      if (log_q.size() == 8 && exp_q.size() == 0) break;
      m_ready = pat[c % 4];
      tick();
    end
    m_ready = 1'b1;
    repeat (3) tick();
    check("t3_count", log_q.size(), 8);
    for (int n = 0; n < 8; n++)
      if (n < log_q.size())
        check($sformatf("t3_beat[%0d]", n), log_q[n], {2'd1, 32'(n + 1)});
    wait_drain("t3");

    // ---- test 4: BURST_LEN=1, ports 0 and 3 alternate ----
    do_reset();
    s_valid1          = 4'b1001;
    s_data1           = '0;
    s_data1[0 +: 32]  = 32'h100;
    s_data1[96 +: 32] = 32'h300;
    m_ready1          = 1'b1;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      if (c == 0) exp_rdy = '0;
      else begin
        k = c - 1;
        exp_rdy = (k % 2 != 0) ? 4'b0000 : (((k / 2) % 2 == 0) ? 4'b0001 : 4'b1000);
      end
      exp_mv  = 1'b0;
      exp_dst = '0;
      exp_dat = '0;
      if (c >= 2) begin
        j = c - 2;
        exp_mv  = (j % 2 == 0);
        exp_dst = ((j / 2) % 2 == 0) ? 2'd0 : 2'd3;
        exp_dat = ((j / 2) % 2 == 0) ? 32'h100 : 32'h300;
      end
      check($sformatf("t4_tready[%0d]", c), s_ready1, exp_rdy);
      check($sformatf("t4_mvalid[%0d]", c), m_valid1, exp_mv);
      if (exp_mv) begin
        check($sformatf("t4_mdest[%0d]", c), m_dest1, exp_dst);
        check($sformatf("t4_mdata[%0d]", c), m_data1, exp_dat);
      end
      tick();
    end
    s_valid1 = '0;
    repeat (3) tick();

    // ---- test 5: reset mid-burst with a held output beat ----
    do_reset();
    left[0] = 20;
    val[0]  = 32'h500;
    auto_en = 1'b1;
    drive();
    for (int c = 0; c < 40; c++) begin
      if (acc[0] >= 5) break;
      tick();
    end
    check("t5_accepted", acc[0], 5);
    m_ready = 1'b0;
    left[1] = 4;
    val[1]  = 32'h600;
    drive();
    @(negedge clk);
    check("t5_held_mvalid", m_valid, 1);
    check("t5_held_mdata", m_data, 32'h504);
    check("t5_held_tready", s_ready, 0);
    tick();
    rst = 1'b1;
    tick();
    rst     = 1'b0;
    m_ready = 1'b1;
    @(negedge clk);
    check("t5_post_mvalid", m_valid, 0);
    check("t5_post_tready", s_ready, 0);
    check("t5_post_mdata", m_data, 0);
    check("t5_post_mdest", m_dest, 0);
    tick();
    @(negedge clk);
    check("t5_first_grant", s_ready, 4'b0001);
    tick();
    for (int i = 0; i < 4; i++) left[i] = 0;
    drive();
    wait_drain("t5");

    // ---- test 6: port 3 gap releases grant; waiting port 0 goes next ----
    do_reset();
    left[3] = 5;
    val[3]  = 32'h30;
    auto_en = 1'b1;
    log_en  = 1'b1;
    drive();
    tick();
    left[0] = 3;
    val[0]  = 32'h00;
    drive();
    gapped = 1'b0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (acc[3] == 2) begin
        gap[3] = 1'b1;
        drive();
        gapped = 1'b1;
        tick();
        gap[3] = 1'b0;
        drive();
        @(negedge clk);
        check("t6_idle", s_ready, 0);
        tick();
        @(negedge clk);
        check("t6_grant0", s_ready, 4'b0001);
        break;
      end
    end
    check("t6_gap_seen", gapped, 1);
    wait_drain("t6");
    t6_exp[0] = {2'd3, 32'h30};
    t6_exp[1] = {2'd3, 32'h31};
    t6_exp[2] = {2'd0, 32'h00};
    t6_exp[3] = {2'd0, 32'h01};
    t6_exp[4] = {2'd0, 32'h02};
    t6_exp[5] = {2'd3, 32'h32};
    t6_exp[6] = {2'd3, 32'h33};
    t6_exp[7] = {2'd3, 32'h34};
    check("t6_count", log_q.size(), 8);
    for (int n = 0; n < 8; n++)
      if (n < log_q.size())
        check($sformatf("t6_beat[%0d]", n), log_q[n], t6_exp[n]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
